down_cnt256: RTL and testbench

//  Presettable 8-bit down-counter; the counting-down counterpart of the team's 8-bit nibble up-counter.

---
 rtl/down_cnt256_pkg.sv | 14 +
 rtl/down_cnt256_if.sv | 30 +++
 rtl/down_cnt256_cnt16.sv | 41 ++++
 rtl/down_cnt256.sv | 113 +++++++++++
 tb/tb_down_cnt256.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/down_cnt256_pkg.sv
// Shared types for the 8-bit presettable down-counter.
//   cnt_t   : 8-bit count value, {high nibble, low nibble}
//   state_e : control FSM states
package down_cnt256_pkg;

  typedef logic [7:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/down_cnt256_if.sv
// Bus bundle for down_cnt256.
//   load : synchronous load strobe          d    : load value
//   en   : count enable                     mode : 0 one-shot, 1 auto-reload (sampled on load)
//   qh/ql: count nibbles                    b    : terminal-count pulse
//   busy : counter running                  done : one-shot finished
// master drives the controls and observes the outputs; slave is the counter.
interface down_cnt256_if;
  import down_cnt256_pkg::*;

  logic       load;
  cnt_t       d;
  logic       en;
  logic       mode;
  logic [3:0] qh;
  logic [3:0] ql;
  logic       b;
  logic       busy;
  logic       done;

  modport master (
    output load, d, en, mode,
    input  qh, ql, b, busy, done
  );

  modport slave (
    input  load, d, en, mode,
    output qh, ql, b, busy, done
  );

endinterface

// File: rtl/down_cnt256_cnt16.sv
// 4-bit loadable down-counter slice (one nibble of down_cnt256).
//   clk/rst : clock, asynchronous active-high reset (to RstVal)
//   ld, d   : synchronous load, has priority over dec
//   dec     : decrement by one (wraps 0 -> F)
//   q       : current value
//   bo      : borrow out = dec & (q == 0), combinational
module down_cnt256_cnt16 #(
  parameter logic [3:0] RstVal = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       dec,
  output logic [3:0] q,
  output logic       bo
);

  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (dec) begin
      q_d = q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign bo = dec & (q_q == 4'h0);

endmodule

// File: rtl/down_cnt256.sv
// Presettable 8-bit down-counter with terminal-count pulse, one-shot and auto-reload modes.
//   clk      : clock, rising edge
//   rst      : master reset, asynchronous, active-high
//   bus      : slave side of down_cnt256_if (load/d/en/mode in; qh/ql/b/busy/done out)
// Parameters:
//   RST_VAL   : count and reload value while reset is asserted
//   RELOAD_EN : 0 forces one-shot regardless of mode
module down_cnt256
  import down_cnt256_pkg::*;
#(
  parameter cnt_t RST_VAL   = 8'h00,
  parameter bit   RELOAD_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  down_cnt256_if.slave   bus
);

  state_e state_d, state_q;
  cnt_t   r_d, r_q;
  logic   mode_d, mode_q;
  logic   b_d, b_q;
  logic   busy_d, busy_q;
  logic   done_d, done_q;

  cnt_t       q;
  logic [3:0] qh, ql;
  logic       step, is_one, term;
  logic       nib_ld, dec_lo, lo_bo, hi_bo;
  cnt_t       nib_d;

  assign q      = {qh, ql};
  assign is_one = (q == 8'd1);
  // Load outranks counting, so a load on the terminal edge suppresses the pulse.
  assign step   = (state_q == StRun) & bus.en & ~bus.load;
  assign term   = step & is_one;
  assign dec_lo = step & ~is_one;

  // Terminal count reuses the load path: reload R in auto-reload, clear to 0 in one-shot.
  assign nib_ld = bus.load | term;
  assign nib_d  = bus.load ? bus.d : (mode_q ? r_q : 8'h00);

  down_cnt256_cnt16 #(
    .RstVal(RST_VAL[3:0])
  ) u_lo (
    .clk(clk),
    .rst(rst),
    .ld (nib_ld),
    .d  (nib_d[3:0]),
    .dec(dec_lo),
    .q  (ql),
    .bo (lo_bo)
  );

  down_cnt256_cnt16 #(
    .RstVal(RST_VAL[7:4])
  ) u_hi (
    .clk(clk),
    .rst(rst),
    .ld (nib_ld),
    .d  (nib_d[7:4]),
    .dec(lo_bo),
    .q  (qh),
    .bo (hi_bo)
  );

  // Decrement only happens with q > 1, so the high nibble can never borrow out.
  assert property (@(posedge clk) disable iff (rst) !hi_bo);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    mode_d  = mode_q;
    b_d     = 1'b0;
    if (bus.load) begin
      r_d     = bus.d;
      mode_d  = bus.mode & RELOAD_EN;
      state_d = (bus.d != 8'h00) ? StRun : StDone;
    end else if (term) begin
      b_d = 1'b1;
      if (!mode_q) begin
        state_d = StDone;
      end
    end
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= RST_VAL;
      mode_q  <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.qh   = qh;
  assign bus.ql   = ql;
  assign bus.b    = b_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_down_cnt256.sv
`timescale 1ns/1ps
module tb_down_cnt256;

  logic clk = 1'b0;
  logic rst = 1'b0;

  down_cnt256_if bus ();

  down_cnt256 #(
    .RST_VAL  (8'h00),
    .RELOAD_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #2 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: count value, reload value, mode, run/done flags, pulse.
  logic [7:0] m_q    = 8'h00;
  logic [7:0] m_r    = 8'h00;
  logic       m_mode = 1'b0;
  logic       m_run  = 1'b0;
  logic       m_done = 1'b0;
  logic       m_b    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 8'h00; m_r <= 8'h00; m_mode <= 1'b0;
      m_run <= 1'b0; m_done <= 1'b0; m_b <= 1'b0;
    end else if (bus.load) begin
      m_q    <= bus.d;
      m_r    <= bus.d;
      m_mode <= bus.mode;
      m_run  <= (bus.d != 0);
      m_done <= (bus.d == 0);
      m_b    <= 1'b0;
    end else if (m_run && bus.en) begin
      if (m_q == 1) begin
        m_b <= 1'b1;
        if (m_mode) begin
          m_q <= m_r;
        end else begin
          m_q <= 8'h00; m_run <= 1'b0; m_done <= 1'b1;
        end
      end else begin
        m_q <= m_q - 8'd1;
        m_b <= 1'b0;
      end
    end else begin
      m_b <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_q",    {bus.qh, bus.ql}, m_q);
    chk("cmp_b",    {7'd0, bus.b},    {7'd0, m_b});
    chk("cmp_busy", {7'd0, bus.busy}, {7'd0, m_run});
    chk("cmp_done", {7'd0, bus.done}, {7'd0, m_done});
  end

  int nb;
  int nd;

  initial begin
    bus.load = 1'b1; bus.d = 8'h55; bus.en = 1'b0; bus.mode = 1'b0;

    // 1: async reset visible before any clock edge; load ignored under reset
    #0.5 rst = 1'b1;
    #0.5;
    chk("rst_q",    {bus.qh, bus.ql}, 8'h00);
    chk("rst_b",    {7'd0, bus.b},    8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_done", {7'd0, bus.done}, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_hold_q", {bus.qh, bus.ql}, 8'h00);
    rst = 1'b0; bus.load = 1'b0;

    // 2: one-shot from 3
    @(negedge clk); bus.load = 1'b1; bus.d = 8'h03; bus.mode = 1'b0; bus.en = 1'b1;
    @(negedge clk); chk("os_q3", {bus.qh, bus.ql}, 8'h03); bus.load = 1'b0;
    @(negedge clk); chk("os_q2", {bus.qh, bus.ql}, 8'h02); chk("os_b2", {7'd0, bus.b}, 8'h00);
    @(negedge clk); chk("os_q1", {bus.qh, bus.ql}, 8'h01);
    @(negedge clk);
    chk("os_q0", {bus.qh, bus.ql}, 8'h00);
    chk("os_b",  {7'd0, bus.b},    8'h01);
    chk("os_done", {7'd0, bus.done}, 8'h01);
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.b) nb++;
      chk("os_hold_q", {bus.qh, bus.ql}, 8'h00);
    end
    chk("os_extra_b", nb[7:0], 8'h00);

    // 3: nibble borrow and enable gating
    bus.load = 1'b1; bus.d = 8'h10; bus.en = 1'b0;
    @(negedge clk); bus.load = 1'b0; bus.en = 1'b1;
    @(negedge clk); bus.en = 1'b0; chk("borrow_q", {bus.qh, bus.ql}, 8'h0F);
    repeat (3) begin @(negedge clk); chk("gate_q0f", {bus.qh, bus.ql}, 8'h0F); end
    bus.en = 1'b1;
    @(negedge clk); bus.en = 1'b0; chk("burst_q0e", {bus.qh, bus.ql}, 8'h0E);
    repeat (2) begin @(negedge clk); chk("gate_q0e", {bus.qh, bus.ql}, 8'h0E); end
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    bus.en = 1'b0; chk("burst_q0c", {bus.qh, bus.ql}, 8'h0C);

    // 4: auto-reload divide-by-4 over 40 enabled cycles
    @(negedge clk); bus.load = 1'b1; bus.d = 8'h04; bus.mode = 1'b1;
    @(negedge clk); bus.load = 1'b0; bus.en = 1'b1;
    nb = 0; nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.b) nb++;
      if (bus.done) nd++;
    end
    bus.en = 1'b0;
    chk("ar_pulses", nb[7:0], 8'd10);
    chk("ar_done",   nd[7:0], 8'd0);
    chk("ar_q",      {bus.qh, bus.ql}, 8'h04);

    // 5: load beats terminal count; load of zero goes straight to done
    @(negedge clk); bus.load = 1'b1; bus.d = 8'h02; bus.mode = 1'b0;
    @(negedge clk); bus.load = 1'b0; bus.en = 1'b1;
    @(negedge clk); chk("ld_pre_q1", {bus.qh, bus.ql}, 8'h01); bus.load = 1'b1; bus.d = 8'h22;
    @(negedge clk);
    chk("ld_q22", {bus.qh, bus.ql}, 8'h22);
    chk("ld_nob", {7'd0, bus.b},    8'h00);
    bus.d = 8'h00;
    @(negedge clk);
    chk("ld0_q",    {bus.qh, bus.ql}, 8'h00);
    chk("ld0_done", {7'd0, bus.done}, 8'h01);
    chk("ld0_b",    {7'd0, bus.b},    8'h00);
    chk("ld0_busy", {7'd0, bus.busy}, 8'h00);
    bus.load = 1'b0; bus.en = 1'b0;

    // 6: async reset mid-count in auto-reload mode
    @(negedge clk); bus.load = 1'b1; bus.d = 8'h08; bus.mode = 1'b1;
    @(negedge clk); bus.load = 1'b0; bus.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_pre_q", {bus.qh, bus.ql}, 8'h05);
    #1 rst = 1'b1;
    #0.5;
    chk("mr_q",    {bus.qh, bus.ql}, 8'h00);
    chk("mr_b",    {7'd0, bus.b},    8'h00);
    chk("mr_busy", {7'd0, bus.busy}, 8'h00);
    chk("mr_done", {7'd0, bus.done}, 8'h00);
    #18.5 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_q",    {bus.qh, bus.ql}, 8'h00);
      chk("idle_busy", {7'd0, bus.busy}, 8'h00);
    end
    bus.en = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
